stopwatch_timebase: RTL and testbench
=====================================

Name: stopwatch_timebase

Overview:
- Timekeeping datapath that sits directly downstream of the stopwatch control FSM.
- Divides the system clock down to a centisecond tick and counts elapsed time as 8 packed BCD digits.
- Holds a lap/saved register that is captured on the FSM's `write` strobe.
- Supplies both 32-bit values (`live_time`, `saved_time`) to the display-select mux, which is driven by the FSM's `select`.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- TICK_HZ, 100, count resolution in Hz (one tick per centisecond).
- DIV, CLK_HZ/TICK_HZ (derived localparam), prescaler modulus; must be >= 2. Prescaler width is clog2(DIV).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- en  input  1  count enable (same `en` that drives the control FSM); counts while high.
- clear  input  1  synchronous clear of the running time and prescaler.
- write  input  1  one-cycle capture strobe from the control FSM (SAVE state).
- live_time  output  32  running time, BCD {H1,H0,M1,M0,S1,S0,C1,C0}, 4 bits per digit, H1 in [31:28].
- saved_time  output  32  last captured time, same format.
- tick  output  1  one-cycle pulse on each counted centisecond.
- rollover  output  1  one-cycle pulse when time wraps 99:59:59.99 -> 00:00:00.00.

Behaviour:
- Reset (async): prescaler=0, live_time=0, saved_time=0, tick=0, rollover=0.
- All outputs are registered.
- Prescaler:
  - en=1: increments each clk.
  - On reaching DIV-1 with en=1: wraps to 0 and asserts tick for exactly that cycle (registered, visible next cycle).
  - en=0: holds its value, so a pause keeps the partial centisecond; tick=0.
- Counting: when tick fires, live_time increments by one centisecond in the same edge that registers tick. BCD carry chain:
  - C0 0..9 -> C1 0..9 (centiseconds 00..99).
  - S0 0..9 -> S1 0..5 (seconds 00..59).
  - M0 0..9 -> M1 0..5 (minutes 00..59).
  - H0 0..9 -> H1 0..9 (hours 00..99).
  - Each digit resets to 0 when it carries. No digit ever holds a non-BCD value.
- Rollover: incrementing from 99:59:59.99 yields all zeros and pulses rollover for one cycle, coincident with that tick.
- Clear (synchronous):
  - Prescaler=0, live_time=0, tick=0, rollover=0. saved_time is unchanged.
  - Clear has priority over en/tick in the same cycle.
- Write:
  - saved_time <= live_time as registered before the edge.
  - With a same-cycle tick, the pre-increment value is captured.
  - With a same-cycle clear, the pre-clear value is captured.
  - write=0: saved_time holds.
- Continuous write: write held high captures every cycle. This is legal; the FSM normally asserts it for one cycle.
- Reset mid-count: everything returns to zero immediately. Counting restarts from prescaler 0 after reset deasserts.
- No handshake back to the FSM; all inputs are sampled each clk with no buffering.

Test Plan (bench uses CLK_HZ=1000, TICK_HZ=100, so DIV=10):
- Basic count: en=1 for 100 clks from reset -> 10 tick pulses, each 10 clks apart; live_time=0x00000010.
- Pause retains phase:
  - Stimulus: en=1 for 15 clks, en=0 for 50 clks, en=1 for 5 clks.
  - Response: exactly 2 ticks total; the second tick comes 5 clks after re-enable; live_time=0x00000002; no tick while en=0.
- Carry chain / rollover:
  - Preload live_time to 0x00595999 via clear-free counting or a force, then one tick -> 0x01000000.
  - Preload 0x99595999, then one tick -> 0x00000000 with a rollover pulse of width 1; rollover never fires otherwise.
- Write/tick collision: with live_time=0x00000009, assert write in the same cycle the tick fires -> saved_time=0x00000009, live_time=0x00000010.
- Clear priority:
  - Stimulus: clear and write asserted together with live_time=0x00001234.
  - Response: live_time=0, saved_time=0x00001234, prescaler restarts; next tick arrives 10 clks after en resumes.
- Async reset mid-run: assert reset between clk edges during counting -> all outputs read 0 before the next clk edge; tick and rollover stay low while reset is held.

Source files
------------

// File: rtl/stopwatch_timebase_if.sv
// Signal bundle between the stopwatch control FSM and the timebase datapath.
// The FSM drives the control strobes; the timebase returns both time values
// plus its tick/rollover pulses.
interface stopwatch_timebase_if;
    logic        en;
    logic        clear;
    logic        write;
    logic [31:0] live_time;
    logic [31:0] saved_time;
    logic        tick;
    logic        rollover;

    // Control side (FSM / testbench)
    modport master (
        output en,
        output clear,
        output write,
        input  live_time,
        input  saved_time,
        input  tick,
        input  rollover
    );

    // Datapath side (stopwatch_timebase)
    modport slave (
        input  en,
        input  clear,
        input  write,
        output live_time,
        output saved_time,
        output tick,
        output rollover
    );
endinterface

// File: rtl/stopwatch_timebase.sv
// Stopwatch timebase: divides clk down to a centisecond tick, counts elapsed
// time as 8 packed BCD digits {H1,H0,M1,M0,S1,S0,C1,C0} and keeps a lap
// register captured on the FSM write strobe. All outputs are registered.
module stopwatch_timebase #(
    parameter int unsigned CLK_HZ  = 100000000,
    parameter int unsigned TICK_HZ = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    stopwatch_timebase_if.slave   bus
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    // Highest legal value of each digit; also the value that wraps to zero.
    localparam logic [31:0] DIGIT_MAX = 32'h9959_5999;

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   live_q,  live_d;
    logic [31:0]   saved_q;
    logic          tick_q,  tick_d;
    logic          roll_q,  roll_d;

    logic [31:0]   live_inc;
    logic          carry;

    // BCD increment of the running time by one centisecond, ripple carry
    // from C0 upward; carry out of H1 means the 99:59:59.99 wrap.
    always_comb begin
        live_inc = live_q;
        carry    = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            if (carry) begin
                if (live_q[i*4 +: 4] >= DIGIT_MAX[i*4 +: 4]) begin
                    live_inc[i*4 +: 4] = 4'd0;
                end else begin
                    live_inc[i*4 +: 4] = live_q[i*4 +: 4] + 4'd1;
                    carry              = 1'b0;
                end
            end
        end
    end

    // Next-state for prescaler, running time and pulses; clear beats en/tick.
    always_comb begin
        presc_d = presc_q;
        live_d  = live_q;
        tick_d  = 1'b0;
        roll_d  = 1'b0;
        if (bus.clear) begin
            presc_d = '0;
            live_d  = '0;
        end else if (bus.en) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
                live_d  = live_inc;
                roll_d  = carry;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // State registers; the lap register samples the pre-edge running time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            live_q  <= '0;
            saved_q <= '0;
            tick_q  <= 1'b0;
            roll_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            live_q  <= live_d;
            tick_q  <= tick_d;
            roll_q  <= roll_d;
            if (bus.write) begin
                saved_q <= live_q;
            end
        end
    end

    assign bus.live_time  = live_q;
    assign bus.saved_time = saved_q;
    assign bus.tick       = tick_q;
    assign bus.rollover   = roll_q;

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Directed bench for stopwatch_timebase with CLK_HZ=1000, TICK_HZ=100 (DIV=10).
module tb_stopwatch_timebase;

    logic clk;
    logic reset;
    int   vectors;
    int   errors;

    stopwatch_timebase_if bus ();

    stopwatch_timebase #(
        .CLK_HZ  (1000),
        .TICK_HZ (100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clock edges, sampling 1ns after each edge; report pulse counts
    // and the 1-based edge index of the first tick / rollover (0 if none).
    task automatic run(input int n, output int nt, output int first_tick,
                       output int nr, output int first_roll);
        nt = 0; nr = 0; first_tick = 0; first_roll = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (bus.tick === 1'b1) begin
                nt++;
                if (first_tick == 0) first_tick = i;
            end
            if (bus.rollover === 1'b1) begin
                nr++;
                if (first_roll == 0) first_roll = i;
            end
        end
    endtask

    task automatic do_clear();
        int nt, ft, nr, fr;
        bus.clear = 1'b1;
        run(1, nt, ft, nr, fr);
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (bus.live_time !== 32'h0) begin
            errors++; $display("FAIL reset_live: got %h want %h", bus.live_time, 32'h0);
        end
        vectors++;
        if (bus.saved_time !== 32'h0) begin
            errors++; $display("FAIL reset_saved: got %h want %h", bus.saved_time, 32'h0);
        end
        vectors++;
        if (bus.tick !== 1'b0) begin
            errors++; $display("FAIL reset_tick: got %b want 0", bus.tick);
        end
        vectors++;
        if (bus.rollover !== 1'b0) begin
            errors++; $display("FAIL reset_rollover: got %b want 0", bus.rollover);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_count();
        int prev, nt, nr;
        prev = 0; nt = 0; nr = 0;
        bus.en = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.rollover === 1'b1) nr++;
            if (bus.tick === 1'b1) begin
                nt++;
                vectors++;
                if (i - prev != 10) begin
                    errors++; $display("FAIL basic_tick_spacing: tick at edge %0d, previous %0d, want gap 10", i, prev);
                end
                prev = i;
            end
        end
        bus.en = 1'b0;
        vectors++;
        if (nt != 10) begin
            errors++; $display("FAIL basic_tick_count: got %0d want 10", nt);
        end
        vectors++;
        if (bus.live_time !== 32'h0000_0010) begin
            errors++; $display("FAIL basic_live: got %h want %h", bus.live_time, 32'h0000_0010);
        end
        vectors++;
        if (nr != 0) begin
            errors++; $display("FAIL basic_no_rollover: got %0d pulses want 0", nr);
        end
    endtask

    task automatic test_pause();
        int nt1, ft1, nt2, ft2, nt3, ft3, nr, fr;
        do_clear();
        bus.en = 1'b1;
        run(15, nt1, ft1, nr, fr);
        bus.en = 1'b0;
        run(50, nt2, ft2, nr, fr);
        bus.en = 1'b1;
        run(5, nt3, ft3, nr, fr);
        bus.en = 1'b0;
        vectors++;
        if (nt1 + nt2 + nt3 != 2) begin
            errors++; $display("FAIL pause_total_ticks: got %0d want 2", nt1 + nt2 + nt3);
        end
        vectors++;
        if (nt2 != 0) begin
            errors++; $display("FAIL pause_tick_while_paused: got %0d want 0", nt2);
        end
        vectors++;
        if (ft3 != 5) begin
            errors++; $display("FAIL pause_resume_phase: tick at edge %0d after resume, want 5", ft3);
        end
        vectors++;
        if (bus.live_time !== 32'h0000_0002) begin
            errors++; $display("FAIL pause_live: got %h want %h", bus.live_time, 32'h0000_0002);
        end
    endtask

    task automatic test_carry();
        int nt, ft, nr, fr;
        do_clear();
        force dut.live_q = 32'h0059_5999;
        #1;
        release dut.live_q;
        bus.en = 1'b1;
        run(10, nt, ft, nr, fr);
        bus.en = 1'b0;
        vectors++;
        if (ft != 10 || nt != 1) begin
            errors++; $display("FAIL carry_tick: %0d ticks first at %0d, want 1 at 10", nt, ft);
        end
        vectors++;
        if (bus.live_time !== 32'h0100_0000) begin
            errors++; $display("FAIL carry_live: got %h want %h", bus.live_time, 32'h0100_0000);
        end
        vectors++;
        if (nr != 0) begin
            errors++; $display("FAIL carry_no_rollover: got %0d pulses want 0", nr);
        end
    endtask

    task automatic test_rollover();
        int nt, ft, nr, fr;
        do_clear();
        force dut.live_q = 32'h9959_5999;
        #1;
        release dut.live_q;
        bus.en = 1'b1;
        run(10, nt, ft, nr, fr);
        vectors++;
        if (bus.live_time !== 32'h0) begin
            errors++; $display("FAIL rollover_live: got %h want %h", bus.live_time, 32'h0);
        end
        vectors++;
        if (nr != 1 || fr != 10 || ft != 10) begin
            errors++; $display("FAIL rollover_pulse: %0d pulses first at %0d (tick %0d), want 1 at 10", nr, fr, ft);
        end
        run(12, nt, ft, nr, fr);
        bus.en = 1'b0;
        vectors++;
        if (nr != 0) begin
            errors++; $display("FAIL rollover_width: got %0d extra pulses want 0", nr);
        end
        vectors++;
        if (bus.live_time !== 32'h0000_0001) begin
            errors++; $display("FAIL rollover_continue: got %h want %h", bus.live_time, 32'h0000_0001);
        end
    endtask

    task automatic test_write_tick();
        int nt, ft, nr, fr;
        do_clear();
        bus.en = 1'b1;
        run(99, nt, ft, nr, fr);
        vectors++;
        if (bus.live_time !== 32'h0000_0009) begin
            errors++; $display("FAIL wt_pre_live: got %h want %h", bus.live_time, 32'h0000_0009);
        end
        bus.write = 1'b1;
        run(1, nt, ft, nr, fr);
        bus.write = 1'b0;
        bus.en    = 1'b0;
        vectors++;
        if (bus.tick !== 1'b1) begin
            errors++; $display("FAIL wt_tick: got %b want 1", bus.tick);
        end
        vectors++;
        if (bus.saved_time !== 32'h0000_0009) begin
            errors++; $display("FAIL wt_saved: got %h want %h", bus.saved_time, 32'h0000_0009);
        end
        vectors++;
        if (bus.live_time !== 32'h0000_0010) begin
            errors++; $display("FAIL wt_live: got %h want %h", bus.live_time, 32'h0000_0010);
        end
        run(5, nt, ft, nr, fr);
        vectors++;
        if (bus.saved_time !== 32'h0000_0009) begin
            errors++; $display("FAIL wt_saved_hold: got %h want %h", bus.saved_time, 32'h0000_0009);
        end
    endtask

    task automatic test_clear_priority();
        int nt, ft, nr, fr;
        do_clear();
        bus.en = 1'b1;
        // 1234 ticks plus 9 edges leaves the prescaler one edge from a tick.
        run(12349, nt, ft, nr, fr);
        vectors++;
        if (bus.live_time !== 32'h0000_1234) begin
            errors++; $display("FAIL clr_pre_live: got %h want %h", bus.live_time, 32'h0000_1234);
        end
        bus.clear = 1'b1;
        bus.write = 1'b1;
        run(1, nt, ft, nr, fr);
        bus.clear = 1'b0;
        bus.write = 1'b0;
        vectors++;
        if (bus.live_time !== 32'h0) begin
            errors++; $display("FAIL clr_live: got %h want %h", bus.live_time, 32'h0);
        end
        vectors++;
        if (bus.saved_time !== 32'h0000_1234) begin
            errors++; $display("FAIL clr_saved: got %h want %h", bus.saved_time, 32'h0000_1234);
        end
        vectors++;
        if (bus.tick !== 1'b0) begin
            errors++; $display("FAIL clr_tick: got %b want 0", bus.tick);
        end
        run(10, nt, ft, nr, fr);
        bus.en = 1'b0;
        vectors++;
        if (ft != 10 || nt != 1) begin
            errors++; $display("FAIL clr_restart: %0d ticks first at %0d, want 1 at 10", nt, ft);
        end
    endtask

    task automatic test_async_reset();
        int nt, ft, nr, fr;
        do_clear();
        bus.en = 1'b1;
        run(20, nt, ft, nr, fr);
        vectors++;
        if (bus.tick !== 1'b1 || bus.live_time !== 32'h0000_0002) begin
            errors++; $display("FAIL ar_pre: tick %b live %h, want 1 and %h", bus.tick, bus.live_time, 32'h0000_0002);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.live_time !== 32'h0 || bus.saved_time !== 32'h0) begin
            errors++; $display("FAIL ar_times: live %h saved %h, want 0 and 0", bus.live_time, bus.saved_time);
        end
        vectors++;
        if (bus.tick !== 1'b0 || bus.rollover !== 1'b0) begin
            errors++; $display("FAIL ar_pulses: tick %b rollover %b, want 0 and 0", bus.tick, bus.rollover);
        end
        run(15, nt, ft, nr, fr);
        vectors++;
        if (nt != 0 || nr != 0 || bus.live_time !== 32'h0) begin
            errors++; $display("FAIL ar_held: ticks %0d rollovers %0d live %h, want 0 0 0", nt, nr, bus.live_time);
        end
        @(negedge clk);
        reset = 1'b0;
        run(10, nt, ft, nr, fr);
        bus.en = 1'b0;
        vectors++;
        if (ft != 10 || nt != 1 || bus.live_time !== 32'h0000_0001) begin
            errors++; $display("FAIL ar_restart: %0d ticks first at %0d live %h, want 1 at 10 live 1", nt, ft, bus.live_time);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vectors   = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.en    = 1'b0;
        bus.clear = 1'b0;
        bus.write = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_basic_count();
        test_pause();
        test_carry();
        test_rollover();
        test_write_tick();
        test_clear_priority();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
